reloj_display_scan: RTL and testbench
=====================================

// Module: reloj_display_scan
// PURPOSE
//   Reader side of the reloj time bus: captures the HH:MM BCD time that reloj publishes
//   and drives a 4-digit multiplexed common-anode 7-segment display.
//   Sits between reloj and the board display pins.
//   Frame-synchronous snapshot prevents digit tearing.
//   Adds inter-digit blanking against ghosting and a 1 Hz colon blink.
// PARAMETERS
//   SCAN_DIV  50000  clk cycles a digit is lit (SHOW); 1 ms at 50 MHz; must be >=2
//   GAP_CYC   500    clk cycles all anodes off between digits (GAP); 0 = no GAP state
// PORTS
//   clk        in   1   system clock, 50 MHz, single clock domain
//   rst_n      in   1   synchronous, active-low reset
//   time_bcd   in   16  {h_tens,h_units,m_tens,m_units}, 4-bit BCD each
//   time_valid in   1   1-cycle strobe: time_bcd holds a new value
//   sec_tick   in   1   1-cycle strobe once per second from reloj
//   an         out  4   anode enables, active-low, an[0] = m_units ... an[3] = h_tens
//   seg        out  7   {g,f,e,d,c,b,a}, active-low
//   dp         out  1   decimal point / colon, active-low
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//     an=4'b1111, seg=7'h7F, dp=1; cap_reg=disp_reg=16'h0000; colon=0; state=IDLE;
//     digit index idx=0; prescaler=0; have_time=0.
//   Capture:
//     time_valid=1 -> cap_reg<=time_bcd next edge and have_time<=1.
//     Later strobes overwrite cap_reg.
//   FSM: IDLE -> SHOW -> GAP -> SHOW ... (GAP skipped when GAP_CYC=0)
//     IDLE: outputs blank; leave when have_time=1, loading disp_reg<=cap_reg, idx=0.
//     SHOW: drive digit idx for SCAN_DIV cycles (prescaler 0..SCAN_DIV-1),
//       then go to GAP, or advance idx directly when GAP_CYC=0.
//     GAP: an=1111, seg=7F, dp=1 for GAP_CYC cycles, then idx<=idx+1 mod 4 and go to SHOW.
//   Frame boundary (idx wraps 3->0):
//     disp_reg<=cap_reg. If time_valid is high in that same cycle,
//     disp_reg<=time_bcd (bypass), so the newest value wins.
//   disp_reg never changes mid-frame.
//   Outputs registered: an/seg/dp reflect state/idx with 1-cycle latency, glitch-free.
//   Decode: 0-9 standard patterns (0=7'h40, 1=7'h79, 8=7'h00, 9=7'h10 active-low).
//     Nibble >9 -> dash, seg=7'h3F (g only).
//   Colon: sec_tick=1 -> colon<=~colon. dp=~colon only while SHOW and idx=2, else dp=1.
//   sec_tick and time_valid in the same cycle: both take effect, independently.
//   Reset mid-frame: everything returns to IDLE values at that edge; cap_reg is cleared.
//     Display stays blank until the next time_valid.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined:
//     when disp_reg h_tens==0, digit 3 stays dark during its SHOW slot (an[3]=1, seg=7F).
//     Slot timing is unchanged.
//   Not defined: h_tens==0 shows "0".
//   No other configuration difference.
// TESTING (bench SCAN_DIV=4, GAP_CYC=2, clk 20 ns)
//   Reset held 3 cycles -> an=1111 seg=7F dp=1.
//     Stays blank 20 cycles without time_valid.
//   time_valid with 16'h1234 -> one frame, ordered:
//     an=1110/seg=h19, an=1101/seg=h30, an=1011/seg=h24, an=0111/seg=h79.
//     Each lit 4 cycles, 2 blank cycles between digits.
//   time_valid 16'h0959 mid-frame while showing 12:34 -> rest of frame still 12:34.
//     0959 appears from next idx=0.
//     Strobe exactly on wrap cycle -> new value shown in that frame.
//   sec_tick x3 -> dp low during idx=2 SHOW after ticks 1 and 3.
//     dp high after tick 2; dp always 1 on other digits.
//   time_bcd 16'hA5F0 -> digits 3 and 1 show seg=3F (dash); 5 and 0 decode normally.
//   rst_n low mid-SHOW of idx=2 -> next cycle all blank, IDLE.
//     With LEADING_ZERO_BLANK_EN, 16'h0930 -> digit 3 slot an=1111.

Source files
------------

// File: rtl/reloj_display_scan.sv
// reloj_display_scan
//   Reader side of the reloj time bus. Captures the HH:MM BCD time published by reloj and
//   scans it onto a 4-digit multiplexed common-anode 7-segment display. The displayed value
//   is only reloaded at frame boundaries, so a digit never tears mid-frame. All anodes are
//   switched off between digits to suppress ghosting, and the colon (dp of digit 2) blinks
//   by toggling on each second tick.
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     When defined, digit 3 (hour tens) stays dark during its slot if it is zero.
//
// Ports
//   clk        in   1   system clock
//   rst_n      in   1   synchronous active-low reset
//   time_bcd   in  16   {h_tens, h_units, m_tens, m_units}, BCD
//   time_valid in   1   strobe: time_bcd carries a new value
//   sec_tick   in   1   strobe once per second
//   an         out  4   anode enables, active-low, an[0] = m_units .. an[3] = h_tens
//   seg        out  7   {g,f,e,d,c,b,a}, active-low
//   dp         out  1   colon, active-low
module reloj_display_scan #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned GAP_CYC  = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] time_bcd,
   input  logic        time_valid,
   input  logic        sec_tick,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int unsigned MAX_CYC = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
   localparam int unsigned PW      = $clog2(MAX_CYC) + 1;

   localparam logic [PW-1:0] SHOW_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] GAP_LAST  = (GAP_CYC == 0) ? '0 : PW'(GAP_CYC - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SHOW = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam logic [3:0] AN_OFF  = 4'b1111;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   logic [1:0]    state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   cap_q, cap_d;
   logic [15:0]   disp_q, disp_d;
   logic          have_time_q, have_time_d;
   logic          colon_q, colon_d;
   logic          advance;

   logic [3:0]    an_d;
   logic [6:0]    seg_d;
   logic          dp_d;
   logic [3:0]    digit;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F; // non-BCD nibble: dash (g only)
      endcase
      return s;
   endfunction

   // Capture, colon toggle and scan sequencing
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      presc_d     = presc_q;
      cap_d       = cap_q;
      disp_d      = disp_q;
      have_time_d = have_time_q;
      colon_d     = colon_q;
      advance     = 1'b0;

      if (time_valid) begin
         cap_d       = time_bcd;
         have_time_d = 1'b1;
      end

      if (sec_tick) begin
         colon_d = ~colon_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (have_time_q) begin
               state_d = ST_SHOW;
               disp_d  = cap_q;
               idx_d   = 2'd0;
               presc_d = '0;
            end
         end
         ST_SHOW: begin
            if (presc_q == SHOW_LAST) begin
               presc_d = '0;
               if (GAP_CYC == 0) begin
                  advance = 1'b1;
               end else begin
                  state_d = ST_GAP;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         ST_GAP: begin
            if (presc_q == GAP_LAST) begin
               presc_d = '0;
               state_d = ST_SHOW;
               advance = 1'b1;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (advance) begin
         idx_d = idx_q + 2'd1;
         // Frame boundary: reload the shown value; a strobe in this very cycle wins.
         if (idx_q == 2'd3) begin
            disp_d = time_valid ? time_bcd : cap_q;
         end
      end
   end

   // Output decode from the current state; registered below for glitch-free pins
   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      digit = disp_q[{idx_q, 2'b00} +: 4];

      if (state_q == ST_SHOW) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = bcd_to_seg(digit);
         dp_d  = (idx_q == 2'd2) ? ~colon_q : 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
         if (idx_q == 2'd3 && digit == 4'd0) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= 2'd0;
         presc_q     <= '0;
         cap_q       <= 16'h0000;
         disp_q      <= 16'h0000;
         have_time_q <= 1'b0;
         colon_q     <= 1'b0;
         an          <= AN_OFF;
         seg         <= SEG_OFF;
         dp          <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         presc_q     <= presc_d;
         cap_q       <= cap_d;
         disp_q      <= disp_d;
         have_time_q <= have_time_d;
         colon_q     <= colon_d;
         an          <= an_d;
         seg         <= seg_d;
         dp          <= dp_d;
      end
   end

endmodule

// File: tb/tb_reloj_display_scan.sv
module tb_reloj_display_scan;

   localparam int SD   = 4;
   localparam int GC   = 2;
   localparam int SLOT = SD + GC;
   localparam int P    = 4 * SLOT;

   logic        clk;
   logic        rst_n;
   logic [15:0] time_bcd;
   logic        time_valid;
   logic        sec_tick;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int checks = 0;
   int errors = 0;

   reloj_display_scan #(
      .SCAN_DIV (SD),
      .GAP_CYC  (GC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .time_bcd   (time_bcd),
      .time_valid (time_valid),
      .sec_tick   (sec_tick),
      .an         (an),
      .seg        (seg),
      .dp         (dp)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Reference model: the display is a pure function of elapsed time since scanning began,
   // the strobe history and the number of second ticks.
   int          n = 0;          // edges seen
   bit          have = 0;
   int          sc = 0;         // first edge whose outputs show digit 0
   int          ticks = 0;      // ticks through the current edge
   int          ticks_prev = 0; // ticks through the previous edge
   int          s_edge [$];
   logic [15:0] s_val  [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @edge %0d: got %h expected %h", tag, n, got, exp);
      end
   endtask

   function automatic logic [6:0] pattern(input logic [3:0] d);
      logic [6:0] tbl [10];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return (d > 4'd9) ? 7'h3F : tbl[d];
   endfunction

   // Newest strobed value at or before edge lim
   function automatic logic [15:0] value_at(input int lim);
      for (int i = s_edge.size() - 1; i >= 0; i--)
         if (s_edge[i] <= lim) return s_val[i];
      return 16'h0000;
   endfunction

   function automatic logic [11:0] expect_out();
      int d, f, p, dig;
      logic [15:0] v;
      logic [3:0]  nib;
      logic [3:0]  ea;
      logic        edp;
      if (!have || n < sc) return {4'hF, 7'h7F, 1'b1};
      d   = n - sc;
      f   = d / P;
      p   = d % P;
      dig = p / SLOT;
      if ((p % SLOT) >= SD) return {4'hF, 7'h7F, 1'b1};
      v   = value_at((f == 0) ? sc - 2 : sc + f * P - 1);
      v   = v >> (dig * 4);
      nib = v[3:0];
`ifdef LEADING_ZERO_BLANK_EN
      if (dig == 3 && nib == 4'd0) return {4'hF, 7'h7F, 1'b1};
`endif
      ea  = 4'hF;
      ea[dig] = 1'b0;
      edp = (dig == 2) ? ~ticks_prev[0] : 1'b1;
      return {ea, pattern(nib), edp};
   endfunction

   task automatic cyc(input bit r, input bit tv, input logic [15:0] b, input bit tk,
                      input string tag);
      @(negedge clk);
      rst_n      = r;
      time_valid = tv;
      time_bcd   = b;
      sec_tick   = tk;
      @(posedge clk);
      n++;
      if (!r) begin
         have = 0;
         ticks = 0;
         ticks_prev = 0;
         s_edge.delete();
         s_val.delete();
      end else begin
         ticks_prev = ticks;
         if (tk) ticks++;
         if (tv) begin
            s_edge.push_back(n);
            s_val.push_back(b);
            if (!have) begin
               have = 1;
               sc   = n + 2;
            end
         end
      end
      #2;
      check(tag, {20'd0, an, seg, dp}, {20'd0, expect_out()});
   endtask

   task automatic idle(input int k, input string tag);
      for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, 16'h0000, 1'b0, tag);
   endtask

   logic [3:0] ord_an  [4];
   logic [6:0] ord_seg [4];
   int         guard;

   initial begin
      rst_n      = 1'b0;
      time_valid = 1'b0;
      time_bcd   = 16'h0000;
      sec_tick   = 1'b0;
      ord_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      ord_seg = '{7'h19, 7'h30, 7'h24, 7'h79};

      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0, "reset");
      check("reset_blank", {20'd0, an, seg, dp}, {20'd0, 4'hF, 7'h7F, 1'b1});
      idle(20, "no_time");

      // 12:34, ordered frame with explicit constants at each slot start
      cyc(1'b1, 1'b1, 16'h1234, 1'b0, "strobe_1234");
      idle(1, "idle_exit");
      for (int k = 0; k < 4; k++) begin
         idle(1, "frame_1234");
         check("order_an", {28'd0, an}, {28'd0, ord_an[k]});
         check("order_seg", {25'd0, seg}, {25'd0, ord_seg[k]});
         idle(SLOT - 1, "frame_1234");
      end

      // Mid-frame strobe: rest of the frame stays 12:34
      idle(SLOT, "pre_mid");
      cyc(1'b1, 1'b1, 16'h0959, 1'b0, "strobe_mid");
      idle(2 * P, "after_mid");

      // Strobe exactly on the wrap cycle: shown in that frame
      guard = 0;
      while (((n + 2 - sc) % P) != 0 && guard < 2 * P) begin
         idle(1, "seek_wrap");
         guard++;
      end
      check("seek_wrap_bound", guard < 2 * P, 1);
      cyc(1'b1, 1'b1, 16'h2107, 1'b0, "strobe_wrap");
      idle(1, "wrap_digit0");
      check("wrap_bypass_seg", {25'd0, seg}, {25'd0, 7'h78});

      // Colon: three ticks spaced by a frame
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 1'b0, 16'h0000, 1'b1, "tick");
         idle(P, "colon");
      end

      // Non-BCD nibbles show dashes
      cyc(1'b1, 1'b1, 16'hA5F0, 1'b0, "strobe_dash");
      idle(2 * P, "dash");

      // Leading zero hour
      cyc(1'b1, 1'b1, 16'h0930, 1'b1, "strobe_0930");
      idle(2 * P, "lead_zero");

      // Reset in the middle of digit 2
      guard = 0;
      while (!((((n + 1 - sc) % P) / SLOT) == 2 && (((n + 1 - sc) % P) % SLOT) == 1)
             && guard < 2 * P) begin
         idle(1, "seek_d2");
         guard++;
      end
      check("seek_d2_bound", guard < 2 * P, 1);
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, "mid_reset");
      check("mid_reset_an", {28'd0, an}, {28'd0, 4'hF});
      idle(10, "post_reset_blank");

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         logic        r, tv, tk;
         logic [15:0] b;
         r  = ($urandom_range(0, 399) != 0);
         tv = ($urandom_range(0, 29) == 0);
         tk = ($urandom_range(0, 9) == 0);
         b  = ($urandom_range(0, 3) == 0) ? 16'($urandom) :
              {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
               4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
         cyc(r, tv, b, tk, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
